// File: rtl/flash_pkg.sv
// rtl/flash_pkg.sv - shared constants and types for the SPI flash read arbiter
package flash_pkg;
   localparam int         FLASH_ADDR_W    = 24;
   localparam logic [7:0] FLASH_READ_CMD  = 8'h03;
   localparam logic [7:0] FLASH_FILL_BYTE = 8'hFF;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_DMA = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_GRANT,
      ST_ISSUE,
      ST_WAIT,
      ST_ACK
   } flash_state_e;
endpackage

// File: rtl/flash_rr_arb2.sv
// rtl/flash_rr_arb2.sv - two-way round-robin arbiter with a latched last-grant pointer
module flash_rr_arb2
   import flash_pkg::*;
(
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic [1:0] req_i,
   input  logic       advance_i,
   output logic [1:0] grant_o
);

   logic last_q;

   always_comb begin
      grant_o = req_i;
      if (&req_i) begin
         grant_o = (last_q == REQ_DMA) ? 2'b01 : 2'b10;
      end
   end

   // Resetting the pointer to DMA makes the CPU win the first tie.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         last_q <= REQ_DMA;
      end else if (advance_i && (|grant_o)) begin
         last_q <= grant_o[REQ_DMA];
      end
   end

endmodule

// File: rtl/spi_flash_arbiter.sv
// rtl/spi_flash_arbiter.sv - CPU/DMA arbiter for a byte-read SPI flash engine with one-entry cache
module spi_flash_arbiter
   import flash_pkg::*;
#(
   parameter int         ADDR_W    = FLASH_ADDR_W,
   parameter int         TIMEOUT   = 1023,
   parameter logic [7:0] FILL_BYTE = FLASH_FILL_BYTE
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_cpu_req,
   input  logic [ADDR_W-1:0] i_cpu_addr,
   output logic [7:0]        o_cpu_data,
   output logic              o_cpu_ack,
   output logic              o_MemoryReady,
   input  logic              i_dma_req,
   input  logic [ADDR_W-1:0] i_dma_addr,
   output logic [7:0]        o_dma_data,
   output logic              o_dma_ack,
   output logic              o_eng_start,
   output logic [ADDR_W-1:0] o_eng_addr,
   input  logic              i_eng_busy,
   input  logic              i_eng_done,
   input  logic [7:0]        i_eng_data,
   input  logic              i_cache_inv,
   output logic              o_timeout
);

   localparam int              WDW    = $clog2(TIMEOUT + 1);
   localparam logic [WDW-1:0]  WD_MAX = WDW'(TIMEOUT);

   flash_state_e      state_q;
   logic              gnt_q;
   logic [WDW-1:0]    wdog_q;
   logic              cache_valid_q;
   logic [ADDR_W-1:0] cache_addr_q;
   logic [7:0]        cache_data_q;
   logic              cpu_ack_q, dma_ack_q, eng_start_q, timeout_q, mem_ready_q;
   logic [7:0]        cpu_data_q, dma_data_q;
   logic [ADDR_W-1:0] eng_addr_q;

   logic [1:0]        arb_gnt;
   logic              arb_adv;
   logic [ADDR_W-1:0] req_addr;
   logic              cache_hit;
   logic              deliver;
   logic [7:0]        deliver_data;
   logic              cpu_ack_d, dma_ack_d;

   flash_rr_arb2 u_arb (
      .clk_i     (clk),
      .reset_i   (reset),
      .req_i     ({i_dma_req, i_cpu_req}),
      .advance_i (arb_adv),
      .grant_o   (arb_gnt)
   );

   // deliver marks the edge that moves the FSM into ACK; the ack itself is a
   // registered pulse, suppressed if the granted requester has already let go.
   always_comb begin
      arb_adv      = (state_q == ST_IDLE) && (i_cpu_req || i_dma_req) && !cpu_ack_q && !dma_ack_q;
      req_addr     = (gnt_q == REQ_DMA) ? i_dma_addr : i_cpu_addr;
      cache_hit    = cache_valid_q && (cache_addr_q == req_addr);
      deliver      = ((state_q == ST_GRANT) && cache_hit) ||
                     ((state_q == ST_WAIT) && (i_eng_done || (wdog_q == WD_MAX)));
      deliver_data = FILL_BYTE;
      if (state_q == ST_GRANT) begin
         deliver_data = cache_data_q;
      end else if (i_eng_done) begin
         deliver_data = i_eng_data;
      end
      cpu_ack_d    = deliver && (gnt_q == REQ_CPU) && i_cpu_req;
      dma_ack_d    = deliver && (gnt_q == REQ_DMA) && i_dma_req;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         gnt_q         <= REQ_CPU;
         wdog_q        <= '0;
         cache_valid_q <= 1'b0;
         cache_addr_q  <= '0;
         cache_data_q  <= '0;
         cpu_ack_q     <= 1'b0;
         dma_ack_q     <= 1'b0;
         eng_start_q   <= 1'b0;
         timeout_q     <= 1'b0;
         mem_ready_q   <= 1'b1;
         cpu_data_q    <= '0;
         dma_data_q    <= '0;
         eng_addr_q    <= '0;
      end else begin
         eng_start_q <= 1'b0;
         cpu_ack_q   <= cpu_ack_d;
         dma_ack_q   <= dma_ack_d;
         mem_ready_q <= cpu_ack_d || !(i_cpu_req && !cpu_ack_q);
         if (cpu_ack_d) begin
            cpu_data_q <= deliver_data;
         end
         if (dma_ack_d) begin
            dma_data_q <= deliver_data;
         end

         case (state_q)
            ST_IDLE: begin
               if (arb_adv) begin
                  gnt_q   <= (arb_gnt == 2'b10);
                  state_q <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               state_q <= cache_hit ? ST_ACK : ST_ISSUE;
            end
            ST_ISSUE: begin
               if (!i_eng_busy) begin
                  eng_start_q <= 1'b1;
                  eng_addr_q  <= req_addr;
                  wdog_q      <= '0;
                  state_q     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (i_eng_done) begin
                  cache_valid_q <= 1'b1;
                  cache_addr_q  <= eng_addr_q;
                  cache_data_q  <= i_eng_data;
                  state_q       <= ST_ACK;
               end else if (wdog_q == WD_MAX) begin
                  timeout_q <= 1'b1;
                  state_q   <= ST_ACK;
               end else begin
                  wdog_q <= wdog_q + 1'b1;
               end
            end
            ST_ACK: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase

         // Placed after the fill so a coincident invalidate wins.
         if (i_cache_inv) begin
            cache_valid_q <= 1'b0;
         end
      end
   end

   assign o_cpu_data    = cpu_data_q;
   assign o_cpu_ack     = cpu_ack_q;
   assign o_MemoryReady = mem_ready_q;
   assign o_dma_data    = dma_data_q;
   assign o_dma_ack     = dma_ack_q;
   assign o_eng_start   = eng_start_q;
   assign o_eng_addr    = eng_addr_q;
   assign o_timeout     = timeout_q;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// tb/tb_spi_flash_arbiter.sv - directed self-checking bench for spi_flash_arbiter
module tb_spi_flash_arbiter;

   localparam int TO = 1023;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_cpu_req, i_dma_req, i_eng_busy, i_eng_done, i_cache_inv;
   logic [23:0] i_cpu_addr, i_dma_addr;
   logic [7:0]  i_eng_data;
   logic [7:0]  o_cpu_data, o_dma_data;
   logic        o_cpu_ack, o_dma_ack, o_MemoryReady, o_eng_start, o_timeout;
   logic [23:0] o_eng_addr;

   int n_checks = 0;
   int n_fail   = 0;
   int start_cnt = 0;
   int busy_viol = 0;
   int lat, bad, base;

   always #5 clk = ~clk;

   spi_flash_arbiter #(.ADDR_W(24), .TIMEOUT(TO), .FILL_BYTE(8'hFF)) dut (
      .clk           (clk),
      .reset         (reset),
      .i_cpu_req     (i_cpu_req),
      .i_cpu_addr    (i_cpu_addr),
      .o_cpu_data    (o_cpu_data),
      .o_cpu_ack     (o_cpu_ack),
      .o_MemoryReady (o_MemoryReady),
      .i_dma_req     (i_dma_req),
      .i_dma_addr    (i_dma_addr),
      .o_dma_data    (o_dma_data),
      .o_dma_ack     (o_dma_ack),
      .o_eng_start   (o_eng_start),
      .o_eng_addr    (o_eng_addr),
      .i_eng_busy    (i_eng_busy),
      .i_eng_done    (i_eng_done),
      .i_eng_data    (i_eng_data),
      .i_cache_inv   (i_cache_inv),
      .o_timeout     (o_timeout)
   );

   always @(negedge clk) begin
      if (o_eng_start) start_cnt++;
      if (o_eng_start && i_eng_busy) busy_viol++;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic wait_start(input int max, output int n);
      n = 0;
      do begin
         next_cycle();
         mid();
         n++;
      end while (!o_eng_start && n < max);
   endtask

   // Engine answers gap cycles after the start cycle; returns at the ack cycle.
   task automatic eng_reply(input int gap, input logic [7:0] d);
      for (int i = 1; i < gap; i++) next_cycle();
      next_cycle();
      i_eng_done = 1'b1;
      i_eng_data = d;
      next_cycle();
      i_eng_done = 1'b0;
      mid();
   endtask

   initial begin
      #1ms;
      $display("FAIL global_timeout: got 1, expected 0");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      i_cpu_req = 0; i_dma_req = 0; i_eng_busy = 0; i_eng_done = 0; i_cache_inv = 0;
      i_cpu_addr = '0; i_dma_addr = '0; i_eng_data = '0;
      repeat (3) next_cycle();
      mid();
      chk("rst_cpu_ack", o_cpu_ack, 0);
      chk("rst_dma_ack", o_dma_ack, 0);
      chk("rst_start", o_eng_start, 0);
      chk("rst_timeout", o_timeout, 0);
      chk("rst_ready", o_MemoryReady, 1);
      chk("rst_cpu_data", o_cpu_data, 0);
      chk("rst_dma_data", o_dma_data, 0);
      chk("rst_eng_addr", o_eng_addr, 0);
      next_cycle();
      reset = 1'b0;

      // Single CPU miss, engine answers 40 cycles after start
      next_cycle();
      i_cpu_req = 1; i_cpu_addr = 24'h000123;
      wait_start(10, lat);
      chk("miss_start_lat", lat, 3);
      chk("miss_eng_addr", o_eng_addr, 24'h000123);
      chk("miss_ready_low", o_MemoryReady, 0);
      bad = 0;
      for (int i = 1; i < 40; i++) begin
         next_cycle();
         mid();
         if (o_MemoryReady || o_cpu_ack || o_eng_start) bad++;
      end
      chk("miss_wait_quiet", bad, 0);
      next_cycle();
      i_eng_done = 1; i_eng_data = 8'h5A;
      mid();
      chk("miss_no_early_ack", o_cpu_ack, 0);
      next_cycle();
      i_eng_done = 0;
      mid();
      chk("miss_ack", o_cpu_ack, 1);
      chk("miss_data", o_cpu_data, 8'h5A);
      chk("miss_ready_at_ack", o_MemoryReady, 1);
      next_cycle();
      i_cpu_req = 0;
      mid();
      chk("miss_ack_pulse", o_cpu_ack, 0);
      chk("miss_one_start", start_cnt, 1);

      // Cache hit, then invalidate forces a miss
      next_cycle();
      i_cpu_req = 1; i_cpu_addr = 24'h000123;
      base = start_cnt;
      next_cycle();
      mid();
      chk("hit_not_yet", o_cpu_ack, 0);
      chk("hit_ready_low", o_MemoryReady, 0);
      next_cycle();
      mid();
      chk("hit_ack", o_cpu_ack, 1);
      chk("hit_data", o_cpu_data, 8'h5A);
      next_cycle();
      i_cpu_req = 0;
      chk("hit_no_start", start_cnt, base);
      next_cycle();
      i_cache_inv = 1;
      next_cycle();
      i_cache_inv = 0;
      i_cpu_req = 1;
      wait_start(10, lat);
      chk("inv_miss_lat", lat, 3);
      eng_reply(5, 8'h77);
      chk("inv_ack", o_cpu_ack, 1);
      chk("inv_data", o_cpu_data, 8'h77);
      next_cycle();
      i_cpu_req = 0;

      // Contention from fresh reset: CPU first, then DMA
      reset = 1;
      next_cycle();
      reset = 0;
      next_cycle();
      i_cpu_req = 1; i_cpu_addr = 24'h000010;
      i_dma_req = 1; i_dma_addr = 24'h000020;
      wait_start(10, lat);
      chk("cont1_addr", o_eng_addr, 24'h000010);
      eng_reply(3, 8'hC1);
      chk("cont1_cpu_ack", o_cpu_ack, 1);
      chk("cont1_dma_ack", o_dma_ack, 0);
      chk("cont1_cpu_data", o_cpu_data, 8'hC1);
      next_cycle();
      i_cpu_req = 0;
      wait_start(10, lat);
      chk("cont2_lat", lat, 3);
      chk("cont2_addr", o_eng_addr, 24'h000020);
      eng_reply(3, 8'hD2);
      chk("cont2_dma_ack", o_dma_ack, 1);
      chk("cont2_dma_data", o_dma_data, 8'hD2);
      chk("cont2_cpu_hold", o_cpu_data, 8'hC1);
      next_cycle();
      i_dma_req = 0;
      // A lone CPU read moves the pointer to CPU, so the next tie goes to DMA
      next_cycle();
      i_cpu_req = 1;
      wait_start(10, lat);
      eng_reply(3, 8'hC1);
      chk("solo_cpu_ack", o_cpu_ack, 1);
      next_cycle();
      i_cpu_req = 0;
      next_cycle();
      i_cpu_req = 1; i_dma_req = 1;
      wait_start(10, lat);
      chk("cont3_dma_first", o_eng_addr, 24'h000020);
      eng_reply(3, 8'hD2);
      chk("cont3_dma_ack", o_dma_ack, 1);
      chk("cont3_cpu_wait", o_cpu_ack, 0);
      next_cycle();
      i_dma_req = 0;
      // CPU now granted, but withdraws before completion: ack suppressed, cache filled
      wait_start(10, lat);
      chk("drop_addr", o_eng_addr, 24'h000010);
      i_cpu_req = 0;
      eng_reply(3, 8'h99);
      chk("drop_no_ack", o_cpu_ack, 0);
      chk("drop_data_held", o_cpu_data, 8'hC1);
      next_cycle();
      i_cpu_req = 1;
      next_cycle();
      next_cycle();
      mid();
      chk("drop_cache_hit_ack", o_cpu_ack, 1);
      chk("drop_cache_hit_data", o_cpu_data, 8'h99);
      next_cycle();
      i_cpu_req = 0;

      // Engine busy holds off the start pulse
      next_cycle();
      i_cpu_req = 1; i_cpu_addr = 24'h000300; i_eng_busy = 1;
      bad = 0;
      for (int i = 0; i < 12; i++) begin
         next_cycle();
         mid();
         if (o_eng_start) bad++;
      end
      chk("busy_no_start", bad, 0);
      next_cycle();
      i_eng_busy = 0;
      mid();
      chk("busy_fall_no_start", o_eng_start, 0);
      next_cycle();
      mid();
      chk("busy_start_next", o_eng_start, 1);
      eng_reply(2, 8'h3C);
      chk("busy_data", o_cpu_data, 8'h3C);
      next_cycle();
      i_cpu_req = 0;
      chk("busy_viol", busy_viol, 0);

      // Watchdog timeout
      next_cycle();
      i_cpu_req = 1; i_cpu_addr = 24'h000400;
      wait_start(10, lat);
      lat = 0;
      do begin
         next_cycle();
         mid();
         lat++;
      end while (!o_cpu_ack && lat < TO + 10);
      chk("to_ack_lat", lat, TO + 1);
      chk("to_data", o_cpu_data, 8'hFF);
      chk("to_flag", o_timeout, 1);
      next_cycle();
      i_cpu_req = 0;
      repeat (3) next_cycle();
      i_cpu_req = 1;
      wait_start(10, lat);
      chk("to_recheck_miss", lat, 3);
      eng_reply(2, 8'h44);
      chk("to_recheck_data", o_cpu_data, 8'h44);
      chk("to_sticky", o_timeout, 1);
      next_cycle();
      i_cpu_req = 0;

      // Reset during WAIT, then a late done is ignored
      next_cycle();
      i_cpu_req = 1; i_cpu_addr = 24'h000500;
      wait_start(10, lat);
      repeat (5) next_cycle();
      reset = 1; i_cpu_req = 0;
      next_cycle();
      reset = 0;
      mid();
      chk("rmid_ack", o_cpu_ack, 0);
      chk("rmid_ready", o_MemoryReady, 1);
      chk("rmid_cpu_data", o_cpu_data, 0);
      chk("rmid_eng_addr", o_eng_addr, 0);
      chk("rmid_timeout", o_timeout, 0);
      next_cycle();
      i_eng_done = 1; i_eng_data = 8'hAB;
      next_cycle();
      i_eng_done = 0;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         mid();
         if (o_cpu_ack || o_dma_ack || o_eng_start) bad++;
         next_cycle();
      end
      chk("rmid_late_done_ignored", bad, 0);
      chk("rmid_data_still_zero", o_cpu_data, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_flash_arbiter.md
Name: spi_flash_arbiter

Overview:
- Shares one SPI flash read engine between two requesters: the 6809 CPU port (wait-stated through o_MemoryReady) and a DMA/boot-copy port.
- Arbitrates between them, sequences the engine's start/done handshake, and holds a one-entry read cache (last address and data) so repeated reads skip the SPI transaction.
- Includes a watchdog so a hung engine cannot wait-state the CPU forever.
- Sits between the address decoder/DMA logic and the byte-read SPI engine.

Parameters:
- ADDR_W, 24, flash byte-address width.
- TIMEOUT, 1023, clk cycles allowed from o_eng_start to i_eng_done before abort.
- FILL_BYTE, 8'hFF, data returned on timeout.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- i_cpu_req  in  1  CPU read request; level, held until o_cpu_ack.
- i_cpu_addr  in  ADDR_W  CPU flash address; stable while i_cpu_req is high.
- o_cpu_data  out  8  CPU read data; valid in the o_cpu_ack cycle and held afterwards.
- o_cpu_ack  out  1  one-cycle completion pulse to the CPU.
- o_MemoryReady  out  1  low means hold the 6809 in wait state.
- i_dma_req  in  1  DMA read request; same protocol as CPU.
- i_dma_addr  in  ADDR_W  DMA flash address.
- o_dma_data  out  8  DMA read data.
- o_dma_ack  out  1  one-cycle completion pulse to DMA.
- o_eng_start  out  1  one-cycle start pulse to the SPI read engine.
- o_eng_addr  out  ADDR_W  engine address; held from start until done.
- i_eng_busy  in  1  engine transaction in progress.
- i_eng_done  in  1  one-cycle engine completion pulse.
- i_eng_data  in  8  engine read byte; valid with i_eng_done.
- i_cache_inv  in  1  invalidate the cache entry (e.g. after an external flash write).
- o_timeout  out  1  sticky watchdog error flag.

Behaviour:
- Reset values:
  - o_cpu_ack, o_dma_ack, o_eng_start, o_timeout = 0.
  - o_MemoryReady = 1.
  - o_cpu_data, o_dma_data, o_eng_addr = 0.
  - cache valid = 0; FSM = IDLE; round-robin pointer = CPU-first.
- States:
  - IDLE -> GRANT, when any request is pending and no ack is asserted this cycle.
  - GRANT: on a cache hit (valid and address equal), go to ACK. On a miss, go to ISSUE.
  - ISSUE: wait until i_eng_busy = 0, then pulse o_eng_start for one cycle, clear the watchdog, and go to WAIT.
  - WAIT: on i_eng_done, capture i_eng_data, update the cache, and go to ACK. If the watchdog reaches TIMEOUT, return FILL_BYTE, set o_timeout, leave the cache unchanged, and go to ACK.
  - ACK: pulse the granted requester's ack for one cycle and drive its data; return to IDLE.
- Arbitration:
  - Only one requester pending: grant it.
  - Both pending: round-robin; grant the one not granted last.
  - The grant is latched at GRANT entry; a requester that raises req mid-transaction waits.
- Latency:
  - Cache hit: req sampled high at edge N, ack in cycle N+2.
  - Miss: ack follows i_eng_done by 1 cycle.
  - The start pulse occurs no earlier than 2 cycles after req.
- o_MemoryReady is registered:
  - Cleared the cycle after i_cpu_req is sampled high with no ack pending.
  - Set in the same cycle o_cpu_ack asserts; otherwise 1.
- Cache rules:
  - One entry shared by both ports.
  - i_cache_inv clears valid in the next cycle.
  - If i_cache_inv coincides with the fill in WAIT, invalidate wins (valid = 0, data still returned).
- Data outputs hold their last value between acks.
- Requester drops req before ack (protocol violation): the transaction still completes and the cache is updated, but the ack is suppressed.
- i_eng_done outside WAIT is ignored.
- Reset mid-transaction: all state returns to reset values and no ack is issued. An engine still busy is handled by the ISSUE busy-wait on the next request.
- o_timeout clears only on reset.
- Watchdog counter width is clog2(TIMEOUT+1); it saturates and does not wrap.

Decomposition:
- Shared package flash_pkg:
  - State enum (IDLE/GRANT/ISSUE/WAIT/ACK).
  - FLASH_ADDR_W = 24.
  - FLASH_READ_CMD = 8'h03.
  - FILL_BYTE.
  - Requester-ID constants (REQ_CPU = 0, REQ_DMA = 1).
- One sub-module: flash_rr_arb2, a 2-way round-robin arbiter with latched last-grant pointer; inputs req[1:0] and advance, outputs a one-hot grant.

Test Plan:
- Single CPU miss: req addr 0x000123; engine done with 0x5A 40 cycles after start. Expect:
  - o_eng_addr = 0x000123.
  - One start pulse.
  - o_cpu_data = 0x5A and o_cpu_ack one cycle after done.
  - o_MemoryReady low throughout, high at ack.
- Cache hit: repeat CPU read of 0x000123. Expect no o_eng_start, ack 2 cycles after req, data 0x5A. Then pulse i_cache_inv and read again: a new start is issued.
- Contention: CPU and DMA both req in the same cycle (0x000010, 0x000020) and held. Expect CPU served first (fresh reset), then DMA. Repeat with both: DMA first.
- Engine busy: hold i_eng_busy = 1 for 10 cycles after GRANT. Expect o_eng_start exactly 1 cycle after busy falls, never while busy = 1.
- Timeout: never assert done. Expect ack at TIMEOUT + 1 cycles after start, data 0xFF, o_timeout = 1 (sticky), and the next read of the same address misses the cache.
- Reset mid-WAIT: assert reset for 1 cycle during WAIT. Expect no ack, all outputs at reset values, and a late i_eng_done ignored.
